// File: rtl/pixel_calib_pipe.sv
// Multi-lane pixel calibration: per-pixel dark subtract and gain correct, N_PIX lanes per clock.
// A geometry FSM validates frame/row/col structure and tags each accepted beat through a 3-stage datapath.
module pixel_calib_pipe #(
  parameter int N_PIX          = 2,
  parameter int DN_SIZE        = 12,
  parameter int GAIN_SIZE      = 16,
  parameter int GAIN_FRAC      = 14,
  parameter int OUT_SIZE       = 16,
  parameter int N_COL          = 2048,
  parameter int N_ROW          = 2064,
  parameter int FRAME_CNT_SIZE = 20,
  localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1,
  localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1
) (
  input  logic                                  dram_clk,
  input  logic                                  reset_n,
  input  logic                                  bypass,
  input  logic                                  err_clear,
  input  logic                                  pix_valid,
  input  logic                                  fval,
  input  logic                                  lval,
  input  logic [N_PIX*DN_SIZE-1:0]              pix_dn,
  input  logic                                  coeff_valid,
  input  logic [N_PIX*(DN_SIZE+GAIN_SIZE)-1:0]  coeff_data,
  output logic                                  coeff_ack,
  output logic                                  out_valid,
  output logic [N_PIX*OUT_SIZE-1:0]             out_data,
  output logic [ROW_W-1:0]                      out_row,
  output logic [COL_W-1:0]                      out_col,
  output logic [FRAME_CNT_SIZE-1:0]             out_frame,
  output logic                                  error,
  output logic [1:0]                            err_code
);
  localparam int CW   = DN_SIZE + GAIN_SIZE;
  localparam int P_W  = DN_SIZE + GAIN_SIZE + 1;
  localparam int RC_W = $clog2(N_ROW + 1);
  localparam int CC_W = $clog2(N_COL + N_PIX + 1);
  localparam logic [RC_W-1:0] ROW_END  = RC_W'(N_ROW);
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(N_ROW - 1);
  localparam logic [CC_W-1:0] COL_END  = CC_W'(N_COL);
  localparam logic [CC_W-1:0] COL_STEP = CC_W'(N_PIX);
  localparam logic [P_W-1:0]  RND      = P_W'(1) << (GAIN_FRAC - 1);

  typedef enum logic [2:0] {STANDBY, INTERFRAME, INTERLINE, INTRALINE, ERROR} state_t;

  state_t                    state, state_n;
  logic [RC_W-1:0]           row, row_n;
  logic [CC_W-1:0]           col, col_n;
  logic [FRAME_CNT_SIZE-1:0] frame, frame_n;
  logic [1:0]                code_n;
  logic                      beat, tracking, underflow, accept;
  logic [ROW_W-1:0]          tag_row;
  logic [COL_W-1:0]          tag_col;

  always_comb begin
    beat      = pix_valid & fval & lval;
    tracking  = (state == INTERFRAME) || (state == INTERLINE) || (state == INTRALINE);
    coeff_ack = beat & ~bypass & coeff_valid & tracking;
    underflow = beat & ~bypass & ~coeff_valid & tracking;
    state_n   = state;
    row_n     = row;
    col_n     = col;
    frame_n   = frame;
    code_n    = err_code;
    accept    = 1'b0;
    tag_row   = row[ROW_W-1:0];
    tag_col   = col[COL_W-1:0];
    case (state)
      STANDBY: if (pix_valid && !fval) state_n = INTERFRAME;
      INTERFRAME: if (beat) begin
        state_n = INTRALINE;
        row_n   = '0;
        col_n   = COL_STEP;
        accept  = 1'b1;
        tag_row = '0;
        tag_col = '0;
      end
      INTERLINE: begin
        if (beat) begin
          state_n = INTRALINE;
          col_n   = COL_STEP;
          accept  = 1'b1;
          tag_col = '0;
        end else if (pix_valid && !fval) begin
          if (row == ROW_END) begin
            state_n = INTERFRAME;
            frame_n = frame + 1'b1;
          end else begin
            state_n = ERROR;
            code_n  = 2'd3;
          end
        end
      end
      INTRALINE: begin
        if (beat) begin
          if (col >= COL_END) begin
            state_n = ERROR;
            code_n  = 2'd2;
          end else begin
            col_n  = col + COL_STEP;
            accept = 1'b1;
          end
        end else if (pix_valid && !lval) begin
          if (col != COL_END) begin
            state_n = ERROR;
            code_n  = 2'd2;
          end else if (fval) begin
            state_n = INTERLINE;
            row_n   = row + 1'b1;
          end else if (row != ROW_LAST) begin
            state_n = ERROR;
            code_n  = 2'd3;
          end else begin
            state_n = INTERFRAME;
            frame_n = frame + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (underflow) begin
      state_n = ERROR;
      code_n  = 2'd1;
      accept  = 1'b0;
    end
    // err_clear overrides both a held error and one raised in the same cycle
    if (err_clear && state_n == ERROR) begin
      state_n = STANDBY;
      code_n  = '0;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= STANDBY;
      row      <= '0;
      col      <= '0;
      frame    <= '0;
      err_code <= '0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      frame    <= frame_n;
      err_code <= code_n;
    end
  end

  assign error = (state == ERROR);

  logic [N_PIX*DN_SIZE-1:0]   dark_c, dn1, dark1, val_c, val2;
  logic [N_PIX*GAIN_SIZE-1:0] gain_c, gain1, gain2;
  logic [N_PIX*OUT_SIZE-1:0]  res_c;
  logic                       v1, v2, byp1, byp2;
  logic [ROW_W-1:0]           row1, row2;
  logic [COL_W-1:0]           col1, col2;
  logic [FRAME_CNT_SIZE-1:0]  frame1, frame2;
  logic [DN_SIZE:0]           diff;
  logic [P_W-1:0]             prod;

  always_comb begin
    dark_c = '0;
    gain_c = '0;
    for (int unsigned i = 0; i < N_PIX; i++) begin
      dark_c[i*DN_SIZE +: DN_SIZE]     = coeff_data[i*CW +: DN_SIZE];
      gain_c[i*GAIN_SIZE +: GAIN_SIZE] = coeff_data[i*CW + DN_SIZE +: GAIN_SIZE];
    end
  end

  // Bypass carries the raw DN through the diff slot so stage 3 only needs to skip the multiply
  always_comb begin
    val_c = '0;
    diff  = '0;
    for (int unsigned i = 0; i < N_PIX; i++) begin
      diff = {1'b0, dn1[i*DN_SIZE +: DN_SIZE]} - {1'b0, dark1[i*DN_SIZE +: DN_SIZE]};
      if (byp1)
        val_c[i*DN_SIZE +: DN_SIZE] = dn1[i*DN_SIZE +: DN_SIZE];
      else if (!diff[DN_SIZE])
        val_c[i*DN_SIZE +: DN_SIZE] = diff[DN_SIZE-1:0];
    end
  end

  always_comb begin
    res_c = '0;
    prod  = '0;
    for (int unsigned i = 0; i < N_PIX; i++) begin
      if (byp2)
        prod = P_W'(val2[i*DN_SIZE +: DN_SIZE]);
      else
        prod = (P_W'(val2[i*DN_SIZE +: DN_SIZE]) * P_W'(gain2[i*GAIN_SIZE +: GAIN_SIZE]) + RND)
               >> GAIN_FRAC;
      res_c[i*OUT_SIZE +: OUT_SIZE] = (|prod[P_W-1:OUT_SIZE]) ? '1 : prod[OUT_SIZE-1:0];
    end
  end

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0; v2 <= 1'b0; out_valid <= 1'b0;
      byp1 <= 1'b0; dn1 <= '0; dark1 <= '0; gain1 <= '0;
      row1 <= '0; col1 <= '0; frame1 <= '0;
      byp2 <= 1'b0; val2 <= '0; gain2 <= '0;
      row2 <= '0; col2 <= '0; frame2 <= '0;
      out_data <= '0; out_row <= '0; out_col <= '0; out_frame <= '0;
    end else begin
      v1        <= accept;
      v2        <= v1;
      out_valid <= v2;
      if (accept) begin
        byp1   <= bypass;
        dn1    <= pix_dn;
        dark1  <= dark_c;
        gain1  <= gain_c;
        row1   <= tag_row;
        col1   <= tag_col;
        frame1 <= frame;
      end
      if (v1) begin
        byp2   <= byp1;
        val2   <= val_c;
        gain2  <= gain1;
        row2   <= row1;
        col2   <= col1;
        frame2 <= frame1;
      end
      if (v2) begin
        out_data  <= res_c;
        out_row   <= row2;
        out_col   <= col2;
        out_frame <= frame2;
      end
    end
  end
endmodule

// File: tb/tb_pixel_calib_pipe.sv
// Scoreboard bench for pixel_calib_pipe: 2 lanes, 8x2 frames, 2-bit frame counter.
// GAIN_FRAC=8 so that gain 0xFFFF on a full-scale pixel actually drives the output into saturation.
module tb_pixel_calib_pipe;
  localparam int N_PIX = 2, DN = 12, GS = 16, GF = 8, OS = 16, NC = 8, NR = 2, FS = 2;

  logic clk = 1'b0, rst_n = 1'b0, bypass = 1'b0, err_clear = 1'b0;
  logic pix_valid = 1'b0, fval = 1'b0, lval = 1'b0, coeff_valid = 1'b0;
  logic [N_PIX*DN-1:0]      pix_dn = '0;
  logic [N_PIX*(DN+GS)-1:0] coeff_data = '0;
  logic                     coeff_ack, out_valid, error;
  logic [N_PIX*OS-1:0]      out_data;
  logic [0:0]               out_row;
  logic [2:0]               out_col;
  logic [FS-1:0]            out_frame;
  logic [1:0]               err_code;

  always #5 clk = ~clk;

  pixel_calib_pipe #(
    .N_PIX(N_PIX), .DN_SIZE(DN), .GAIN_SIZE(GS), .GAIN_FRAC(GF), .OUT_SIZE(OS),
    .N_COL(NC), .N_ROW(NR), .FRAME_CNT_SIZE(FS)
  ) u_dut (
    .dram_clk(clk), .reset_n(rst_n), .bypass(bypass), .err_clear(err_clear),
    .pix_valid(pix_valid), .fval(fval), .lval(lval), .pix_dn(pix_dn),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ack(coeff_ack),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_frame(out_frame), .error(error), .err_code(err_code)
  );

  typedef struct packed {
    logic [11:0] dn0, dn1, dk0, dk1;
    logic [15:0] g, e0, e1;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    logic [0:0]  row;
    logic [2:0]  col;
    logic [1:0]  frame;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        got;
  vec_t        vecs[8];
  vec_t        zv = '0;
  int unsigned cyc = 0, checks = 0, errors = 0, ack_cnt = 0, a0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (coeff_ack) ack_cnt++;
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual data=%h row=%0d col=%0d frame=%0d required none",
                 out_data, out_row, out_col, out_frame);
      end else begin
        got = q.pop_front();
        if (out_data !== got.data) begin
          errors++;
          $display("FAIL out_data actual=%h required=%h", out_data, got.data);
        end
        checks++;
        if ({out_row, out_col, out_frame} !== {got.row, got.col, got.frame}) begin
          errors++;
          $display("FAIL tags actual row=%0d col=%0d frame=%0d required row=%0d col=%0d frame=%0d",
                   out_row, out_col, out_frame, got.row, got.col, got.frame);
        end
        checks++;
        if (cyc - got.cyc != 3) begin
          errors++;
          $display("FAIL latency actual=%0d required=3", cyc - got.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic pv, input logic fv, input logic lv, input logic cv,
                       input vec_t v, input bit push, input logic [0:0] r,
                       input logic [2:0] c, input logic [1:0] f);
    exp_t e;
    pix_valid   = pv;
    fval        = fv;
    lval        = lv;
    coeff_valid = cv;
    pix_dn      = {v.dn1, v.dn0};
    coeff_data  = {v.g, v.dk1, v.g, v.dk0};
    if (push) begin
      e.data  = {v.e1, v.e0};
      e.row   = r;
      e.col   = c;
      e.frame = f;
      e.cyc   = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, zv, 1'b0, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic uniform(input logic [11:0] dn, input logic [11:0] dk, input logic [15:0] g,
                         input logic [15:0] e);
    for (int unsigned i = 0; i < 8; i++) vecs[i] = '{dn, dn, dk, dk, g, e, e};
  endtask

  // Two lines of four beats; optional two-cycle pix_valid gap mid-line.
  task automatic send_frame(input logic [1:0] f, input bit fall_with_lval, input bit gaps);
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (gaps && b == 2) idle(2);
        drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[r*4+b], 1'b1, r[0], 3'(b*2), f);
      end
      if (r == 1 && fall_with_lval) drive(1'b1, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);
      else                          drive(1'b1, 1'b1, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);
    end
    if (!fall_with_lval) drive(1'b1, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);
    idle(1);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    uniform(12'd100, 12'd20, 16'h0100, 16'd80);
    // Frame in progress while reset is held
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    pix_valid = 1'b1; fval = 1'b1; lval = 1'b1; coeff_valid = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_tags", 32'({out_row, out_col, out_frame}), 32'd0);
    chk("reset_coeff_ack", 32'(coeff_ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mid-frame beats after reset must be ignored until fval drops
    for (int unsigned i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    chk("standby_no_ack", ack_cnt, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);

    a0 = ack_cnt;
    send_frame(2'd0, 1'b0, 1'b0);
    chk("ack_count_frame0", ack_cnt - a0, 32'd8);

    vecs[0] = '{12'd100,  12'd100,  12'd20,  12'd0,   16'h0100, 16'd80,   16'd100};
    vecs[1] = '{12'd10,   12'd25,   12'd30,  12'd30,  16'h0100, 16'd0,    16'd0};
    vecs[2] = '{12'd4095, 12'd4095, 12'd0,   12'd0,   16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{12'd3,    12'd5,    12'd0,   12'd0,   16'h0080, 16'd2,    16'd3};
    vecs[4] = '{12'd30,   12'd40,   12'd30,  12'd1,   16'h0100, 16'd0,    16'd39};
    vecs[5] = '{12'd1000, 12'd201,  12'd0,   12'd0,   16'h0180, 16'd1500, 16'd302};
    vecs[6] = '{12'd255,  12'd0,    12'd0,   12'd0,   16'h0101, 16'd256,  16'd0};
    vecs[7] = '{12'd4095, 12'd1100, 12'd100, 12'd100, 16'h4000, 16'hFFFF, 16'd64000};
    send_frame(2'd1, 1'b1, 1'b0);

    bypass = 1'b1;
    for (int unsigned i = 0; i < 8; i++)
      vecs[i] = '{12'hABC, 12'h123, 12'hFFF, 12'hFFF, 16'h0000, 16'h0ABC, 16'h0123};
    a0 = ack_cnt;
    send_frame(2'd2, 1'b0, 1'b1);
    chk("bypass_no_ack", ack_cnt - a0, 32'd0);
    bypass = 1'b0;

    uniform(12'd50, 12'd0, 16'h0100, 16'd50);
    send_frame(2'd3, 1'b0, 1'b1);
    send_frame(2'd0, 1'b1, 1'b0);

    // Coefficient underflow on the second beat of a line
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b1, 1'b0, 3'd0, 2'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    chk("underflow_error", 32'(error), 32'd1);
    chk("underflow_code", 32'(err_code), 32'd1);
    a0 = ack_cnt;
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    chk("error_no_ack", ack_cnt - a0, 32'd0);
    chk("error_held_code", 32'(err_code), 32'd1);
    pulse_clear();
    chk("clear_error", 32'(error), 32'd0);
    chk("clear_code", 32'(err_code), 32'd0);
    a0 = ack_cnt;
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b0, 1'b0, 3'd0, 2'd0);
    chk("relock_wait_no_ack", ack_cnt - a0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);

    // Short line: six pixels then lval drops
    for (int unsigned b = 0; b < 3; b++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b1, 1'b0, 3'(b*2), 2'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);
    chk("short_line_error", 32'(error), 32'd1);
    chk("short_line_code", 32'(err_code), 32'd2);
    pulse_clear();
    drive(1'b1, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);

    // Frame with only one row
    for (int unsigned b = 0; b < 4; b++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[0], 1'b1, 1'b0, 3'(b*2), 2'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);
    chk("one_row_no_error_yet", 32'(error), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);
    chk("one_row_error", 32'(error), 32'd1);
    chk("one_row_code", 32'(err_code), 32'd3);
    pulse_clear();
    chk("clear_after_row_error", 32'({error, err_code}), 32'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b1, zv, 1'b0, 1'b0, 3'd0, 2'd0);
    uniform(12'd7, 12'd2, 16'h0200, 16'd10);
    send_frame(2'd1, 1'b0, 1'b1);

    idle(6);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
